// File: rtl/alu_exec_unit_if.sv
// Request/result handshake bundle between a requester and alu_exec_unit.
// The master modport drives requests and consumes results; the slave modport is the unit itself.
interface alu_exec_unit_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        opcode;
  logic [1:0]        instr_type;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [4:0]        shamt;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] result;
  logic              zero;
  logic              illegal;
  logic [3:0]        alu_ctrl;

  modport master (
    output in_valid, opcode, instr_type, op_a, op_b, shamt, out_ready,
    input  in_ready, out_valid, result, zero, illegal, alu_ctrl
  );

  modport slave (
    input  in_valid, opcode, instr_type, op_a, op_b, shamt, out_ready,
    output in_ready, out_valid, result, zero, illegal, alu_ctrl
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Single-issue ALU with a valid/ready handshake; shifts run one bit per cycle unless
// ALU_BARREL_SHIFT_EN is defined, in which case every shift completes in a single cycle.
module alu_exec_unit #(
  parameter int DATA_W  = 16,
  parameter int SHAMT_W = 4
) (
  input  logic           clk,
  input  logic           reset,
  alu_exec_unit_if.slave bus
);
  localparam logic [3:0] CTRL_NONE = 4'b0000;
  localparam logic [3:0] CTRL_AND  = 4'b0001;
  localparam logic [3:0] CTRL_ADD  = 4'b0010;
  localparam logic [3:0] CTRL_SUB  = 4'b0011;
  localparam logic [3:0] CTRL_CMP  = 4'b0100;
  localparam logic [3:0] CTRL_BEQ  = 4'b0101;
  localparam logic [3:0] CTRL_SLL  = 4'b1100;
  localparam logic [3:0] CTRL_SLR  = 4'b1101;
  localparam logic [3:0] CTRL_SLLV = 4'b1110;
  localparam logic [3:0] CTRL_SLRV = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [DATA_W-1:0]  acc_reg, acc_next;
  logic [SHAMT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]         ctrl_reg, ctrl_next;
  logic               illegal_reg, illegal_next;

  logic [3:0]         dec_ctrl;
  logic               dec_shift;
  logic               dec_right;
  logic [SHAMT_W-1:0] dec_amt;
  logic [DATA_W-1:0]  alu_value;
  logic               shamt_unused;

  always_comb begin
    dec_ctrl = CTRL_NONE;
    case (bus.instr_type)
      2'b00: begin
        case (bus.opcode)
          5'd0:    dec_ctrl = CTRL_AND;
          5'd1:    dec_ctrl = CTRL_ADD;
          5'd2:    dec_ctrl = CTRL_SUB;
          5'd3:    dec_ctrl = CTRL_CMP;
          default: dec_ctrl = CTRL_NONE;
        endcase
      end
      2'b01: begin
        case (bus.opcode)
          5'd0:             dec_ctrl = CTRL_AND;
          5'd1, 5'd2, 5'd3: dec_ctrl = CTRL_ADD;
          5'd4:             dec_ctrl = CTRL_BEQ;
          default:          dec_ctrl = CTRL_NONE;
        endcase
      end
      2'b11: begin
        case (bus.opcode)
          5'd0:    dec_ctrl = CTRL_SLL;
          5'd1:    dec_ctrl = CTRL_SLR;
          5'd2:    dec_ctrl = CTRL_SLLV;
          5'd3:    dec_ctrl = CTRL_SLRV;
          default: dec_ctrl = CTRL_NONE;
        endcase
      end
      default: dec_ctrl = CTRL_NONE;
    endcase
  end

  // Shift codes share the 11xx prefix: bit 1 selects op_b as amount, bit 0 selects right shift.
  assign dec_shift    = (dec_ctrl[3:2] == 2'b11);
  assign dec_right    = dec_ctrl[0];
  assign dec_amt      = dec_ctrl[1] ? bus.op_b[SHAMT_W-1:0] : bus.shamt[SHAMT_W-1:0];
  assign shamt_unused = ^bus.shamt;

  always_comb begin
    alu_value = '0;
    case (dec_ctrl)
      CTRL_AND:           alu_value = bus.op_a & bus.op_b;
      CTRL_ADD:           alu_value = bus.op_a + bus.op_b;
      CTRL_SUB, CTRL_BEQ: alu_value = bus.op_a - bus.op_b;
      CTRL_CMP:           alu_value = {{(DATA_W-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
      default:            alu_value = '0;
    endcase
  end

`ifdef ALU_BARREL_SHIFT_EN
  logic [DATA_W-1:0] shift_value;
  assign shift_value = dec_right ? (bus.op_a >> dec_amt) : (bus.op_a << dec_amt);
`endif

  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    cnt_next     = cnt_reg;
    ctrl_next    = ctrl_reg;
    illegal_next = illegal_reg;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          ctrl_next    = dec_ctrl;
          illegal_next = (dec_ctrl == CTRL_NONE);
          state_next   = DONE;
          if (dec_shift) begin
`ifdef ALU_BARREL_SHIFT_EN
            acc_next = shift_value;
`else
            acc_next = bus.op_a;
            cnt_next = dec_amt;
            if (dec_amt != '0) begin
              state_next = SHIFT;
            end
`endif
          end else begin
            acc_next = alu_value;
          end
        end
      end
      SHIFT: begin
        // Direction is recovered from the latched control code, so late input changes cannot leak in.
        acc_next = ctrl_reg[0] ? (acc_reg >> 1) : (acc_reg << 1);
        cnt_next = cnt_reg - SHAMT_W'(1);
        if (cnt_reg == SHAMT_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      ctrl_reg    <= CTRL_NONE;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      cnt_reg     <= cnt_next;
      ctrl_reg    <= ctrl_next;
      illegal_reg <= illegal_next;
    end
  end

  assign bus.in_ready  = (state_reg == IDLE) && !reset;
  assign bus.out_valid = (state_reg == DONE);
  assign bus.result    = acc_reg;
  assign bus.zero      = (state_reg == DONE) && (acc_reg == '0);
  assign bus.illegal   = illegal_reg;
  assign bus.alu_ctrl  = ctrl_reg;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expected results are queued at issue and
// compared when out_valid appears, along with latency, hold and reset behaviour.
module tb_alu_exec_unit;
  localparam int DW = 16;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_exec_unit_if #(.DATA_W(DW)) bus ();

  alu_exec_unit #(.DATA_W(DW), .SHAMT_W(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [15:0] result;
    logic        zero;
    logic        illegal;
    logic [3:0]  ctrl;
    logic [6:0]  lat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  function automatic exp_t model(input logic [1:0] t, input logic [4:0] op,
                                 input logic [15:0] a, input logic [15:0] b,
                                 input logic [4:0] sh);
    exp_t       e;
    logic [3:0] n;
    logic       is_shift;
    e        = '0;
    e.lat    = 7'd1;
    n        = 4'd0;
    is_shift = 1'b0;
    if (t == 2'b00) begin
      case (op)
        5'd0: begin e.ctrl = 4'b0001; e.result = a & b; end
        5'd1: begin e.ctrl = 4'b0010; e.result = a + b; end
        5'd2: begin e.ctrl = 4'b0011; e.result = a - b; end
        5'd3: begin e.ctrl = 4'b0100; e.result = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0; end
        default: ;
      endcase
    end else if (t == 2'b01) begin
      case (op)
        5'd0:             begin e.ctrl = 4'b0001; e.result = a & b; end
        5'd1, 5'd2, 5'd3: begin e.ctrl = 4'b0010; e.result = a + b; end
        5'd4:             begin e.ctrl = 4'b0101; e.result = a - b; end
        default: ;
      endcase
    end else if (t == 2'b11) begin
      case (op)
        5'd0: begin e.ctrl = 4'b1100; n = sh[3:0]; e.result = a << n; is_shift = 1'b1; end
        5'd1: begin e.ctrl = 4'b1101; n = sh[3:0]; e.result = a >> n; is_shift = 1'b1; end
        5'd2: begin e.ctrl = 4'b1110; n = b[3:0];  e.result = a << n; is_shift = 1'b1; end
        5'd3: begin e.ctrl = 4'b1111; n = b[3:0];  e.result = a >> n; is_shift = 1'b1; end
        default: ;
      endcase
    end
`ifndef ALU_BARREL_SHIFT_EN
    if (is_shift) e.lat = 7'd1 + 7'(n);
`endif
    e.illegal = (e.ctrl == 4'b0000);
    e.zero    = (e.result == 16'd0);
    return e;
  endfunction

  task automatic scramble_inputs();
    bus.op_a       = 16'($urandom);
    bus.op_b       = 16'($urandom);
    bus.opcode     = 5'($urandom);
    bus.instr_type = 2'($urandom);
    bus.shamt      = 5'($urandom);
  endtask

  task automatic run_op(input logic [1:0] t, input logic [4:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [4:0] sh, input int stall);
    exp_t e;
    int   lat;
    sb.push_back(model(t, op, a, b, sh));
    @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL accept_ready: in_ready=%b required 1", bus.in_ready);
    end
    bus.instr_type = t;
    bus.opcode     = op;
    bus.op_a       = a;
    bus.op_b       = b;
    bus.shamt      = sh;
    bus.in_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    scramble_inputs();
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    e = sb.pop_front();
    tests++;
    if (bus.out_valid !== 1'b1) begin
      fails++;
      $display("FAIL timeout: out_valid=%b after %0d cycles required 1", bus.out_valid, lat);
    end
    tests++;
    if (lat != int'(e.lat)) begin
      fails++;
      $display("FAIL latency: got %0d cycles required %0d", lat, e.lat);
    end
    tests++;
    if (bus.result !== e.result) begin
      fails++;
      $display("FAIL result: got %h required %h", bus.result, e.result);
    end
    tests++;
    if (bus.zero !== e.zero || bus.illegal !== e.illegal) begin
      fails++;
      $display("FAIL flags: zero=%b illegal=%b required zero=%b illegal=%b",
               bus.zero, bus.illegal, e.zero, e.illegal);
    end
    tests++;
    if (bus.alu_ctrl !== e.ctrl || bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL ctrl_ready: alu_ctrl=%b in_ready=%b required alu_ctrl=%b in_ready=0",
               bus.alu_ctrl, bus.in_ready, e.ctrl);
    end
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      tests++;
      if ({bus.out_valid, bus.result, bus.zero, bus.illegal, bus.alu_ctrl, bus.in_ready} !==
          {1'b1, e.result, e.zero, e.illegal, e.ctrl, 1'b0}) begin
        fails++;
        $display("FAIL hold: cycle %0d valid=%b result=%h zero=%b illegal=%b ctrl=%b ready=%b required 1/%h/%b/%b/%b/0",
                 i, bus.out_valid, bus.result, bus.zero, bus.illegal, bus.alu_ctrl, bus.in_ready,
                 e.result, e.zero, e.illegal, e.ctrl);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL consume: out_valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready);
    end
    $display("[TB] op type=%b opc=%0d a=%h b=%h sh=%h -> result=%h zero=%b illegal=%b ctrl=%b lat=%0d",
             t, op, a, b, sh, e.result, e.zero, e.illegal, e.ctrl, lat);
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.opcode    = '0;
    bus.instr_type = '0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.shamt     = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({bus.out_valid, bus.in_ready, bus.result, bus.zero, bus.illegal, bus.alu_ctrl} !== 22'd0) begin
      fails++;
      $display("FAIL reset_state: valid=%b ready=%b result=%h zero=%b illegal=%b ctrl=%b required all 0",
               bus.out_valid, bus.in_ready, bus.result, bus.zero, bus.illegal, bus.alu_ctrl);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release: in_ready=%b required 1", bus.in_ready);
    end
    $display("[TB] reset released");
  endtask

  task automatic test_arith();
    run_op(2'b00, 5'd1, 16'h7FFF, 16'h0001, 5'd0, 0);   // R ADD overflow wrap to sign bit
    run_op(2'b00, 5'd1, 16'hFFFF, 16'h0001, 5'd0, 1);   // R ADD wraps to zero
    run_op(2'b01, 5'd4, 16'h1234, 16'h1234, 5'd0, 0);   // I BEQ equal
    run_op(2'b01, 5'd4, 16'h1234, 16'h1235, 5'd0, 0);   // I BEQ unequal
    run_op(2'b00, 5'd3, 16'hFFFF, 16'h0001, 5'd0, 0);   // CMP signed -1 < 1
    run_op(2'b00, 5'd3, 16'h0001, 16'hFFFF, 5'd0, 0);   // CMP signed 1 < -1 false
    run_op(2'b00, 5'd2, 16'h0000, 16'h0001, 5'd0, 0);   // SUB underflow
    run_op(2'b00, 5'd0, 16'hF0F0, 16'h3C3C, 5'd0, 0);
    run_op(2'b01, 5'd0, 16'h00FF, 16'h0F0F, 5'd0, 0);
    run_op(2'b01, 5'd3, 16'h1000, 16'h0234, 5'd0, 0);
  endtask

  task automatic test_shift();
    run_op(2'b11, 5'd2, 16'h0001, 16'h0005, 5'd0, 0);   // SLLV by 5
    run_op(2'b11, 5'd0, 16'h00A5, 16'h0000, 5'd4, 1);   // SLL by shamt
    run_op(2'b11, 5'd1, 16'h8000, 16'h0000, 5'h13, 0);  // SLR, shamt masked to 3
    run_op(2'b11, 5'd3, 16'hF000, 16'h0FFF, 5'd0, 0);   // SLRV by 15, zero-fill
    run_op(2'b11, 5'd3, 16'hBEEF, 16'h0010, 5'd0, 0);   // SLRV amount 16 wraps to 0
    run_op(2'b11, 5'd0, 16'h8001, 16'h0000, 5'h11, 0);  // SLL by 1, top bit lost
  endtask

  task automatic test_illegal();
    run_op(2'b10, 5'd0, 16'h1111, 16'h2222, 5'd0, 4);   // reserved type, long stall
    run_op(2'b00, 5'd4, 16'h1111, 16'h2222, 5'd0, 0);
    run_op(2'b01, 5'd5, 16'h1111, 16'h2222, 5'd0, 0);
    run_op(2'b11, 5'd4, 16'h1111, 16'h2222, 5'd3, 1);
    run_op(2'b00, 5'd31, 16'hFFFF, 16'hFFFF, 5'd0, 0);
  endtask

  task automatic test_reset_mid_op();
    int seen;
    // Discard during SHIFT (or DONE in the single-cycle shift build).
    @(negedge clk);
    bus.instr_type = 2'b11;
    bus.opcode     = 5'd1;
    bus.op_a       = 16'h8000;
    bus.op_b       = 16'h0000;
    bus.shamt      = 5'h13;
    bus.in_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    tests++;
    if ({bus.out_valid, bus.in_ready, bus.result, bus.alu_ctrl, bus.illegal, bus.zero} !== 22'd0) begin
      fails++;
      $display("FAIL async_reset: valid=%b ready=%b result=%h ctrl=%b illegal=%b zero=%b required all 0",
               bus.out_valid, bus.in_ready, bus.result, bus.alu_ctrl, bus.illegal, bus.zero);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_reset: in_ready=%b required 1", bus.in_ready);
    end
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL discard_shift: out_valid seen %0d cycles required 0", seen);
    end
    $display("[TB] reset during SLR discarded");

    // Discard while a result is waiting in DONE.
    @(negedge clk);
    bus.instr_type = 2'b00;
    bus.opcode     = 5'd1;
    bus.op_a       = 16'h0003;
    bus.op_b       = 16'h0004;
    bus.in_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b1) begin
      fails++;
      $display("FAIL done_before_reset: out_valid=%b required 1", bus.out_valid);
    end
    reset = 1'b1;
    #1;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.result !== 16'h0000) begin
      fails++;
      $display("FAIL reset_in_done: out_valid=%b result=%h required 0/0000", bus.out_valid, bus.result);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    seen = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL discard_done: out_valid seen %0d cycles required 0", seen);
    end
    $display("[TB] reset during DONE discarded");
  endtask

  task automatic test_back_to_back();
    logic [1:0]  t;
    logic [4:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    for (int i = 0; i < 24; i++) begin
      t  = 2'($urandom_range(0, 3));
      op = 5'($urandom_range(0, 5));
      a  = 16'($urandom);
      b  = (i % 5 == 0) ? a : 16'($urandom);
      run_op(t, op, a, b, 5'($urandom), $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_shift();
    test_illegal();
    test_reset_mid_op();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
